// File: rtl/down_timer.sv
// Down-counting timer with one-shot / auto-reload modes, pause (HOLD) and abort.
// All outputs registered; the FSM and its outputs live in one clocked block.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             auto_reload_i,
    input  logic             pause_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    // Power-up values match the reset values so outputs are defined before the first rst.
    state_e           state_q  = ST_IDLE;
    logic [WIDTH-1:0] count_q  = '0;
    logic [WIDTH-1:0] reload_q = '0;
    logic             ar_q     = 1'b0;
    logic             tc_q     = 1'b0;
    logic             busy_q   = 1'b0;
    logic             done_q   = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            ar_q     <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tc_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (start_i) begin
                        if (load_val_i != '0) begin
                            count_q  <= load_val_i;
                            reload_q <= load_val_i;
                            ar_q     <= auto_reload_i;
                            busy_q   <= 1'b1;
                            state_q  <= ST_RUN;
                        end else begin
                            // Zero load completes immediately without ever going busy.
                            count_q <= '0;
                            tc_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (count_q == '0) begin
                        if (ar_q) begin
                            count_q <= reload_q;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else if (pause_i) begin
                        state_q <= ST_HOLD;
                    end else begin
                        count_q <= count_q - WIDTH'(1);
                        tc_q    <= (count_q == WIDTH'(1));
                    end
                end
                ST_HOLD: begin
                    if (abort_i) begin
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!pause_i) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: each driven cycle pushes the expected
// outputs, which are popped and compared one clock edge later.
module tb_down_timer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             auto_reload = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tc, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        int tc;
        int busy;
        int done;
        string tag;
    } exp_t;

    exp_t sb[$];

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .load_val_i   (load_val),
        .auto_reload_i(auto_reload),
        .pause_i      (pause),
        .abort_i      (abort),
        .count_o      (count),
        .tc_o         (tc),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic cyc(input string tag, input bit r, input bit st, input int lv, input bit ar,
                       input bit pa, input bit ab, input int e_cnt, input int e_tc,
                       input int e_busy, input int e_done);
        exp_t e;
        rst = r; start = st; load_val = WIDTH'(lv); auto_reload = ar; pause = pa; abort = ab;
        sb.push_back('{e_cnt, e_tc, e_busy, e_done, tag});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_count"}, int'(count), e.cnt);
            chk({e.tag, "_tc"},    int'(tc),    e.tc);
            chk({e.tag, "_busy"},  int'(busy),  e.busy);
            chk({e.tag, "_done"},  int'(done),  e.done);
        end
    endtask

    task automatic idle(input string tag, input int c, input int t, input int b, input int d);
        cyc(tag, 0, 0, 0, 0, 0, 0, c, t, b, d);
    endtask

    initial begin
        #1;
        chk("powerup_count", int'(count), 0);
        chk("powerup_busy",  int'(busy),  0);
        chk("powerup_tc",    int'(tc),    0);
        chk("powerup_done",  int'(done),  0);

        cyc("rst0", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // One-shot, load 3
        cyc("os_start", 0, 1, 3, 0, 0, 0, 3, 0, 1, 0);
        idle("os_2", 2, 0, 1, 0);
        idle("os_1", 1, 0, 1, 0);
        idle("os_0", 0, 1, 1, 0);
        idle("os_done", 0, 0, 0, 1);
        idle("os_idle", 0, 0, 0, 0);

        // Auto-reload, load 2: period 3, never done; then abort
        cyc("ar_start", 0, 1, 2, 1, 0, 0, 2, 0, 1, 0);
        idle("ar_1a", 1, 0, 1, 0);
        idle("ar_0a", 0, 1, 1, 0);
        idle("ar_2b", 2, 0, 1, 0);
        idle("ar_1b", 1, 0, 1, 0);
        idle("ar_0b", 0, 1, 1, 0);
        idle("ar_2c", 2, 0, 1, 0);
        cyc("ar_abort", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle("ar_idle", 0, 0, 0, 0);

        // Pause two cycles at count 3
        cyc("pa_start", 0, 1, 5, 0, 0, 0, 5, 0, 1, 0);
        idle("pa_4", 4, 0, 1, 0);
        idle("pa_3", 3, 0, 1, 0);
        cyc("pa_hold1", 0, 0, 0, 0, 1, 0, 3, 0, 1, 0);
        cyc("pa_hold2", 0, 0, 0, 0, 1, 0, 3, 0, 1, 0);
        idle("pa_resume", 3, 0, 1, 0);
        idle("pa_2", 2, 0, 1, 0);
        idle("pa_1", 1, 0, 1, 0);
        idle("pa_0", 0, 1, 1, 0);
        idle("pa_done", 0, 0, 0, 1);

        // Abort at count 4, then zero load
        cyc("ab_start", 0, 1, 6, 0, 0, 0, 6, 0, 1, 0);
        idle("ab_5", 5, 0, 1, 0);
        idle("ab_4", 4, 0, 1, 0);
        cyc("ab_abort", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle("ab_idle", 0, 0, 0, 0);
        cyc("zl_start", 0, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        idle("zl_after", 0, 0, 0, 0);

        // Reset mid-run with auto-reload, then a normal one-shot of 1
        cyc("rm_start", 0, 1, 8, 1, 0, 0, 8, 0, 1, 0);
        idle("rm_7", 7, 0, 1, 0);
        idle("rm_6", 6, 0, 1, 0);
        cyc("rm_rst", 1, 1, 4, 1, 1, 1, 0, 0, 0, 0);
        idle("rm_idle", 0, 0, 0, 0);
        cyc("rm_os", 0, 1, 1, 0, 0, 0, 1, 0, 1, 0);
        idle("rm_0", 0, 1, 1, 0);
        idle("rm_done", 0, 0, 0, 1);

        // Start while busy is ignored; load/auto_reload changes do not matter
        cyc("ig_start", 0, 1, 7, 0, 0, 0, 7, 0, 1, 0);
        idle("ig_6", 6, 0, 1, 0);
        idle("ig_5", 5, 0, 1, 0);
        idle("ig_4", 4, 0, 1, 0);
        cyc("ig_restart", 0, 1, 9, 1, 0, 0, 3, 0, 1, 0);
        cyc("ig_2", 0, 0, 9, 1, 0, 0, 2, 0, 1, 0);
        idle("ig_1", 1, 0, 1, 0);
        idle("ig_0", 0, 1, 1, 0);
        idle("ig_done", 0, 0, 0, 1);

        // Abort alone in IDLE ignored; abort with start: start wins
        cyc("ia_abort", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("ia_start", 0, 1, 2, 0, 0, 1, 2, 0, 1, 0);
        idle("ia_1", 1, 0, 1, 0);
        idle("ia_0", 0, 1, 1, 0);
        idle("ia_done", 0, 0, 0, 1);

        // Terminal handling beats pause
        cyc("tp_start", 0, 1, 1, 0, 0, 0, 1, 0, 1, 0);
        idle("tp_0", 0, 1, 1, 0);
        cyc("tp_pause", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        idle("tp_idle", 0, 0, 0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
